// File: rtl/next_queue_sub_logic_pkg.sv
// Shared elevator request queue definitions: floor codes, queue geometry and
// the floor_t entry type used by the add stage, sub stage and controller.
package next_queue_sub_logic_pkg;
    localparam int DEPTH   = 4;
    localparam int ENTRY_W = 2;
    localparam int QUEUE_W = DEPTH * ENTRY_W;
    localparam int TAIL_W  = 3;

    typedef logic [ENTRY_W-1:0] floor_t;

    localparam floor_t FLOOR_A    = 2'b00;
    localparam floor_t FLOOR_B    = 2'b01;
    localparam floor_t FLOOR_C    = 2'b10;
    localparam floor_t FLOOR_D    = 2'b11;
    localparam floor_t EMPTY_FILL = 2'b11;

    // Tail codes 5..7 cannot describe a 4-deep queue; treat them as full.
    function automatic logic [TAIL_W-1:0] sat_tail(input logic [TAIL_W-1:0] tail);
        return (tail > TAIL_W'(DEPTH)) ? TAIL_W'(DEPTH) : tail;
    endfunction
endpackage

// File: rtl/next_queue_sub_logic_pop_shift.sv
// Combinational head removal: shift the queue down one entry, fill the top
// slot with EMPTY_FILL and decrement the valid count when pop is asserted.
module next_queue_sub_logic_pop_shift
    import next_queue_sub_logic_pkg::*;
(
    input  logic               pop,
    input  logic [QUEUE_W-1:0] queue,
    input  logic [TAIL_W-1:0]  tail,
    output logic [QUEUE_W-1:0] queue_next,
    output logic [TAIL_W-1:0]  tail_next
);
    logic [QUEUE_W-1:0] shifted;

    assign shifted = {EMPTY_FILL, queue[QUEUE_W-1:ENTRY_W]};

    // pop is only raised for a non-zero tail, so the decrement never wraps.
    always_comb begin
        queue_next = queue;
        tail_next  = tail;
        if (pop) begin
            queue_next = shifted;
            tail_next  = tail - TAIL_W'(1);
        end
    end
endmodule

// File: rtl/next_queue_sub_logic.sv
// Removal stage of the elevator request queue: pops the head when it matches
// the current floor, with combinational results and a registered copy.
module next_queue_sub_logic
    import next_queue_sub_logic_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  floor_t             pos_lvl,
    input  logic [QUEUE_W-1:0] next_queue_add,
    input  logic [TAIL_W-1:0]  next_tail_add,
    output logic [QUEUE_W-1:0] next_queue_sub,
    output logic [TAIL_W-1:0]  next_tail_sub,
    output logic               stop_at_pos_lvl,
    output logic [QUEUE_W-1:0] queue_q,
    output logic [TAIL_W-1:0]  tail_q,
    output logic               stop_q
);
    logic [TAIL_W-1:0] tail_eff;
    floor_t            head;
    logic              pop;

    assign tail_eff = sat_tail(next_tail_add);
    assign head     = next_queue_add[ENTRY_W-1:0];
    // Only the head is ever compared; validity comes from the tail, not content.
    assign pop      = (tail_eff != '0) && (head == pos_lvl);

    next_queue_sub_logic_pop_shift u_pop_shift (
        .pop        (pop),
        .queue      (next_queue_add),
        .tail       (tail_eff),
        .queue_next (next_queue_sub),
        .tail_next  (next_tail_sub)
    );

    assign stop_at_pos_lvl = pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            queue_q <= {DEPTH{EMPTY_FILL}};
            tail_q  <= '0;
            stop_q  <= 1'b0;
        end else begin
            queue_q <= next_queue_sub;
            tail_q  <= next_tail_sub;
            stop_q  <= stop_at_pos_lvl;
        end
    end
endmodule

// File: tb/tb_next_queue_sub_logic.sv
// Bench for next_queue_sub_logic: directed table, randomized model check,
// and reset corner cases.
module tb_next_queue_sub_logic;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] pos_lvl;
    logic [7:0] next_queue_add;
    logic [2:0] next_tail_add;
    logic [7:0] next_queue_sub;
    logic [2:0] next_tail_sub;
    logic       stop_at_pos_lvl;
    logic [7:0] queue_q;
    logic [2:0] tail_q;
    logic       stop_q;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    next_queue_sub_logic dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pos_lvl         (pos_lvl),
        .next_queue_add  (next_queue_add),
        .next_tail_add   (next_tail_add),
        .next_queue_sub  (next_queue_sub),
        .next_tail_sub   (next_tail_sub),
        .stop_at_pos_lvl (stop_at_pos_lvl),
        .queue_q         (queue_q),
        .tail_q          (tail_q),
        .stop_q          (stop_q)
    );

    typedef struct {
        logic [1:0] pos;
        logic [7:0] queue;
        logic [2:0] tail;
        logic [7:0] exp_queue;
        logic [2:0] exp_tail;
        logic       exp_stop;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: unpack entries, saturate the count, pop the head if it matches.
    task automatic model(input logic [1:0] p, input logic [7:0] q, input logic [2:0] t,
                         output logic [7:0] mq, output logic [2:0] mt, output logic ms);
        int e[4];
        int cnt;
        for (int i = 0; i < 4; i++) e[i] = (q >> (2 * i)) & 3;
        cnt = (t > 4) ? 4 : int'(t);
        ms = 1'b0;
        if (cnt > 0 && e[0] == int'(p)) begin
            for (int i = 0; i < 3; i++) e[i] = e[i + 1];
            e[3] = 3;
            cnt = cnt - 1;
            ms = 1'b1;
        end
        mq = 8'(e[0] + 4 * e[1] + 16 * e[2] + 64 * e[3]);
        mt = 3'(cnt);
    endtask

    task automatic drive(input logic [1:0] p, input logic [7:0] q, input logic [2:0] t);
        @(negedge clk);
        pos_lvl = p;
        next_queue_add = q;
        next_tail_add = t;
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_queue_q"}, queue_q, 8'hFF);
        check({tag, "_tail_q"}, {5'd0, tail_q}, 8'd0);
        check({tag, "_stop_q"}, {7'd0, stop_q}, 8'd0);
    endtask

    vec_t vecs[8];

    initial begin
        logic [7:0] mq;
        logic [2:0] mt;
        logic       ms;
        logic [1:0] rp;
        logic [7:0] rq;
        logic [2:0] rt;

        vecs[0] = '{2'b10, 8'hC6, 3'd1, 8'hF1, 3'd0, 1'b1};
        vecs[1] = '{2'b10, 8'hF1, 3'd1, 8'hF1, 3'd1, 1'b0};
        vecs[2] = '{2'b11, 8'hF1, 3'd1, 8'hF1, 3'd1, 1'b0};
        vecs[3] = '{2'b00, 8'h9C, 3'd4, 8'hE7, 3'd3, 1'b1};
        vecs[4] = '{2'b00, 8'h9C, 3'd0, 8'h9C, 3'd0, 1'b0};
        vecs[5] = '{2'b01, 8'h01, 3'd7, 8'hC0, 3'd3, 1'b1};
        vecs[6] = '{2'b00, 8'h00, 3'd5, 8'hC0, 3'd3, 1'b1};
        vecs[7] = '{2'b01, 8'hF4, 3'd2, 8'hF4, 3'd2, 1'b0};

        rst_n = 1'b0;
        pos_lvl = 2'b10;
        next_queue_add = 8'hC6;
        next_tail_add = 3'd1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        check("rst_comb_queue", next_queue_sub, 8'hF1);
        check("rst_comb_stop", {7'd0, stop_at_pos_lvl}, 8'd1);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].pos, vecs[i].queue, vecs[i].tail);
            check($sformatf("vec%0d_queue", i), next_queue_sub, vecs[i].exp_queue);
            check($sformatf("vec%0d_tail", i), {5'd0, next_tail_sub}, {5'd0, vecs[i].exp_tail});
            check($sformatf("vec%0d_stop", i), {7'd0, stop_at_pos_lvl}, {7'd0, vecs[i].exp_stop});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_queue_q", i), queue_q, vecs[i].exp_queue);
            check($sformatf("vec%0d_tail_q", i), {5'd0, tail_q}, {5'd0, vecs[i].exp_tail});
            check($sformatf("vec%0d_stop_q", i), {7'd0, stop_q}, {7'd0, vecs[i].exp_stop});
        end

        for (int n = 0; n < 300; n++) begin
            rp = 2'($urandom_range(0, 3));
            rq = 8'($urandom);
            rt = 3'($urandom_range(0, 7));
            // Bias toward head matches so pops are well exercised.
            if ($urandom_range(0, 1) == 1) rq[1:0] = rp;
            model(rp, rq, rt, mq, mt, ms);
            drive(rp, rq, rt);
            check("rand_queue", next_queue_sub, mq);
            check("rand_tail", {5'd0, next_tail_sub}, {5'd0, mt});
            check("rand_stop", {7'd0, stop_at_pos_lvl}, {7'd0, ms});
            @(posedge clk);
            #1;
            check("rand_queue_q", queue_q, mq);
            check("rand_tail_q", {5'd0, tail_q}, {5'd0, mt});
            check("rand_stop_q", {7'd0, stop_q}, {7'd0, ms});
        end

        // Asynchronous reset in the middle of operation, after a stop.
        drive(2'b10, 8'hC6, 3'd1);
        @(posedge clk);
        #1;
        check("mid_stop_q_before", {7'd0, stop_q}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_rst");
        check("mid_rst_comb_tail", {5'd0, next_tail_sub}, 8'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_reset_state("post_release");
        @(posedge clk);
        #1;
        check("resume_queue_q", queue_q, 8'hF1);
        check("resume_tail_q", {5'd0, tail_q}, 8'd0);
        check("resume_stop_q", {7'd0, stop_q}, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/next_queue_sub_logic.md
# next_queue_sub_logic

Removal ("sub") stage of the elevator request queue. It takes the queue produced by the add stage, which holds four 2-bit floor entries with the head at the least-significant position. If the head request equals the car's current floor, it pops that request and asserts a stop indication. Results are provided combinationally for the same evaluation and also as a registered copy for the next cycle's queue state.

## Interface
- No parameters. Fixed constants: DEPTH = 4 entries, entry width = 2 bits, floor codes A=2'b00, B=2'b01, C=2'b10, D=2'b11, EMPTY_FILL = 2'b11.
- Clocking: one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock for the registered outputs.
- rst_n  input  1  asynchronous active-low reset.
- pos_lvl  input  2  current car floor.
- next_queue_add  input  8  queue from the add stage; entry i = bits [2i+1:2i]; entry 0 = head.
- next_tail_add  input  3  number of valid entries (0–4); valid entries are indices 0..tail-1.
- next_queue_sub  output  8  queue after the optional pop (combinational).
- next_tail_sub  output  3  valid count after the optional pop (combinational).
- stop_at_pos_lvl  output  1  1 when the head was popped (combinational).
- queue_q  output  8  registered next_queue_sub.
- tail_q  output  3  registered next_tail_sub.
- stop_q  output  1  registered stop_at_pos_lvl.

## Operation
- Effective tail: t = next_tail_add, saturated to 4 for input values 5–7.
- Pop condition: pop = (t != 0) && (entry0 == pos_lvl).
- Only the head is compared. Matches at entries 1–3 never cause a pop. Entries at index ≥ t are never compared, even if they equal pos_lvl.
- When pop = 1:
  - next_queue_sub = {2'b11, entry3, entry2, entry1}, i.e. a logical right shift by 2 with the top entry filled with 2'b11.
  - next_tail_sub = t − 1.
  - stop_at_pos_lvl = 1.
- When pop = 0:
  - next_queue_sub = next_queue_add, passed through unchanged, including invalid slots.
  - next_tail_sub = t.
  - stop_at_pos_lvl = 0.
- At most one entry is removed per evaluation.
- The D code (2'b11) is a legal floor when the entry is valid. Validity is defined solely by t, never by the entry content.

## Timing
- Combinational outputs settle within the same cycle as their inputs, with no clock dependency.
- Registered outputs: on each rising clk edge, queue_q/tail_q/stop_q capture next_queue_sub/next_tail_sub/stop_at_pos_lvl. Latency is 1 cycle.
- Reset: while rst_n = 0, queue_q = 8'hFF, tail_q = 3'd0, stop_q = 0. Reset takes effect immediately and asynchronously, including mid-operation. The first capture happens on the first rising edge after rst_n deasserts.
- Combinational outputs are unaffected by rst_n.
- No handshake; every cycle is an evaluation.

## Structure
- Shared package (elevator queue package): floor code constants A/B/C/D, EMPTY_FILL, DEPTH, entry width, and a floor_t 2-bit typedef. The add stage and the controller use the same package.
- Natural sub-module: queue_pop_shift, the combinational shift-and-fill plus tail decrement. The top level adds the head compare, tail saturation, and the output register.

## Test plan
- pos=C, queue={D,A,B,C} (entry3..0), tail=1 → queue_sub={D,D,A,B}, tail_sub=0, stop=1. Next edge: queue_q=8'b11110001, stop_q=1.
- pos=C, queue={D,D,A,B}, tail=1 → queue_sub unchanged {D,D,A,B}, tail_sub=1, stop=0.
- pos=D, queue={D,D,A,B}, tail=1 → unchanged, stop=0, because the D matches at entries 2–3 are outside the valid range.
- pos=A, queue={C,B,D,A}, tail=4 → queue_sub={D,C,B,D}, tail_sub=3, stop=1. The same input with tail=0 gives no pop and stop=0.
- tail=7, pos=B, queue={A,A,A,B} → treated as tail 4: pop, queue_sub={D,A,A,A}, tail_sub=3.
- Drive rst_n low mid-stream after stop_q=1 → queue_q=8'hFF, tail_q=0, stop_q=0 immediately without a clock. Capture resumes on the first edge after release.
